// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit that owns HI/LO: shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up in a final cycle.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  state_t             state_q, state_d;
  logic               is_div_q, is_div_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic               div0_q, div0_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               is_signed;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo, rem;

  assign is_signed = ~op[0];
  assign rs_mag    = (is_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign rt_mag    = (is_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign prod_fix  = negq_q ? -acc_q : acc_q;
  assign quo       = acc_q[WIDTH-1:0];
  assign rem       = acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    div0_d   = div0_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          is_div_d = op[1];
          negq_d   = is_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
          negr_d   = is_signed & rs_val[WIDTH-1];
          div0_d   = (rt_val == '0);
          cnt_d    = '0;
          if (op[1]) begin
            acc_d  = {{WIDTH{1'b0}}, rs_mag};
            opnd_d = rt_mag;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, rt_mag};
            opnd_d = rs_mag;
          end
          state_d = S_RUN;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else                  acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_FINISH;
      end
      S_FINISH: begin
        if (is_div_q) begin
          // a zero divisor leaves the dividend magnitude as remainder, so the
          // normal remainder sign fix-up already restores rs_val into HI
          lo_d = div0_q ? '1 : (negq_q ? -quo : quo);
          hi_d = negr_q ? -rem : rem;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      acc_q    <= '0;
      opnd_q   <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      div0_q   <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      div0_q   <= div0_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed HI/LO results, latency,
// handshake and MTHI/MTLO behaviour, checked with immediate assertions.
module tb_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  int lat, nbusy, ndone;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // returns at the falling edge right after the accepting rising edge
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic hwe, input logic lwe, input logic [31:0] wd);
    @(negedge clk);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    hi_we  = hwe;
    lo_we  = lwe;
    wdata  = wd;
    @(negedge clk);
    start  = 1'b0;
    hi_we  = 1'b0;
    lo_we  = 1'b0;
  endtask

  // samples falling edges base..44 after acceptance; lat=-1 if done never seen
  task automatic wait_done(input int base, output int l, output int nb, output int nd);
    l  = -1;
    nb = 0;
    nd = 0;
    for (int i = base; i < 45; i++) begin
      if (busy) nb++;
      if (done) begin
        nd++;
        if (l < 0) l = i;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    op     = 2'd0;
    rs_val = '0;
    rt_val = '0;
    hi_we  = 1'b0;
    lo_we  = 1'b0;
    wdata  = '0;

    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // MULT -2 * -1
    issue(2'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    wait_done(0, lat, nbusy, ndone);
    chk("mult_lat", lat, 32'd33);
    chk("mult_busy_cycles", nbusy, 32'd33);
    chk("mult_done_pulses", ndone, 32'd1);
    chk("mult_hi", hi, 32'h0000_0000);
    chk("mult_lo", lo, 32'h0000_0002);

    // MULTU 0xFFFFFFFE * 0xFFFFFFFF
    issue(2'd1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    wait_done(0, lat, nbusy, ndone);
    chk("multu_lat", lat, 32'd33);
    chk("multu_hi", hi, 32'hFFFF_FFFD);
    chk("multu_lo", lo, 32'h0000_0002);

    // DIV -7 / 2
    issue(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0, 32'h0);
    wait_done(0, lat, nbusy, ndone);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);

    // DIV most-negative / -1
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    wait_done(0, lat, nbusy, ndone);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0000_0000);

    // DIVU 7 / 0
    issue(2'd3, 32'h0000_0007, 32'h0000_0000, 1'b0, 1'b0, 32'h0);
    wait_done(0, lat, nbusy, ndone);
    chk("divu0_lat", lat, 32'd33);
    chk("divu0_lo", lo, 32'hFFFF_FFFF);
    chk("divu0_hi", hi, 32'h0000_0007);

    // DIV -7 / 0: HI keeps the signed dividend
    issue(2'd2, 32'hFFFF_FFF9, 32'h0000_0000, 1'b0, 1'b0, 32'h0);
    wait_done(0, lat, nbusy, ndone);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'hFFFF_FFF9);

    // DIVU 100 / 7
    issue(2'd3, 32'd100, 32'd7, 1'b0, 1'b0, 32'h0);
    wait_done(0, lat, nbusy, ndone);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    // second start during RUN is ignored: MULTU 6*7 stands
    issue(2'd1, 32'd6, 32'd7, 1'b0, 1'b0, 32'h0);
    repeat (4) @(negedge clk);
    start  = 1'b1;
    op     = 2'd3;
    rs_val = 32'd1000;
    rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, lat, nbusy, ndone);
    chk("restart_lat", lat, 32'd33);
    chk("restart_done_pulses", ndone, 32'd1);
    chk("restart_lo", lo, 32'd42);
    chk("restart_hi", hi, 32'd0);

    // MTHI + MTLO together in IDLE
    @(negedge clk);
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'h1234_5678;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    chk("mt_hi", hi, 32'h1234_5678);
    chk("mt_lo", lo, 32'h1234_5678);

    // MTHI while busy is dropped; HI/LO hold during RUN. MULT 7 * -3
    issue(2'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    hi_we = 1'b1;
    wdata = 32'hAAAA_5555;
    @(negedge clk);
    hi_we = 1'b0;
    chk("busy_we_hi", hi, 32'h1234_5678);
    chk("busy_hold_lo", lo, 32'h1234_5678);
    wait_done(3, lat, nbusy, ndone);
    chk("mult_mix_lat", lat, 32'd33);
    chk("mult_mix_hi", hi, 32'hFFFF_FFFF);
    chk("mult_mix_lo", lo, 32'hFFFF_FFEB);

    // start and MTLO in the same cycle: write dropped
    issue(2'd3, 32'd100, 32'd7, 1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("start_we_lo", lo, 32'hFFFF_FFEB);
    chk("start_we_busy", {31'd0, busy}, 32'd1);
    wait_done(0, lat, nbusy, ndone);
    chk("start_we_res_lo", lo, 32'd14);
    chk("start_we_res_hi", hi, 32'd2);

    // reset mid-operation
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'd0, 32'd3, 32'd5, 1'b0, 1'b0, 32'h0);
    wait_done(0, lat, nbusy, ndone);
    chk("post_rst_lat", lat, 32'd33);
    chk("post_rst_lo", lo, 32'd15);
    chk("post_rst_hi", hi, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
